// File: rtl/ref_sched.sv
// ref_sched: DDR4 refresh scheduler -- tREFI interval timing, PREA/REF command sequencing and owed-refresh tracking.
// Optional macro REF_POSTPONE_EN: ref_pending may accumulate up to MAX_POSTPONE owed refreshes (otherwise 0/1).
module ref_sched #(
  parameter int T_REFI       = 6240,
  parameter int ALMOST_LEAD  = 64,
  parameter int T_RP         = 16,
  parameter int T_RFC        = 280,
  parameter int MAX_POSTPONE = 8
) (
  input  logic       CK_t,
  input  logic       reset,
  input  logic       clear_refresh,
  input  logic       ref_go,
  output logic       refresh_almost,
  output logic       refresh_done,
  output logic       refresh_busy,
  output logic [3:0] ref_pending,
  output logic       ref_overflow,
  output logic       cmd_cs_n,
  output logic       cmd_act_n,
  output logic       cmd_ras_n,
  output logic       cmd_cas_n,
  output logic       cmd_we_n,
  output logic       cmd_a10
);

  localparam int CW     = (T_REFI > 2) ? $clog2(T_REFI) : 1;
  localparam int TMAX   = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(T_REFI - 1);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(T_REFI - ALMOST_LEAD);
  localparam logic [TW-1:0] TMR_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);
  // Timer loads count the PREA/REF cycle itself, hence the -2.
  localparam logic [TW-1:0] TMR_TRP    = TW'(T_RP - 2);
  localparam logic [TW-1:0] TMR_TRFC   = TW'(T_RFC - 2);

`ifdef REF_POSTPONE_EN
  localparam logic [3:0] PEND_MAX = 4'(MAX_POSTPONE);
`else
  localparam logic [3:0] PEND_MAX = (MAX_POSTPONE >= 1) ? 4'd1 : 4'd0;
`endif

  // Pin order {cs_n, act_n, ras_n, cas_n, we_n, a10}.
  localparam logic [5:0] PIN_DESEL = 6'b111110;
  localparam logic [5:0] PIN_PREA  = 6'b010101;
  localparam logic [5:0] PIN_REF   = 6'b010010;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_PREA = 3'd1,
    R_TRP  = 3'd2,
    R_REF  = 3'd3,
    R_TRFC = 3'd4,
    R_DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   intv_q, intv_d;
  logic [3:0]      pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic [5:0]      pins_q, pins_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            wrap_s, clr_s, inc_s, dec_s, almost_s;

  assign almost_s = (intv_q >= CNT_ALMOST) || (pend_q != 4'd0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      R_IDLE: begin
        if (ref_go && almost_s) begin
          state_d = R_PREA;
        end else begin
          state_d = R_IDLE;
        end
      end
      R_PREA: begin
        state_d = R_TRP;
        tmr_d   = TMR_TRP;
      end
      R_TRP: begin
        if (tmr_q == TMR_ZERO) begin
          state_d = R_REF;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      R_REF: begin
        state_d = R_TRFC;
        tmr_d   = TMR_TRFC;
      end
      R_TRFC: begin
        if (tmr_q == TMR_ZERO) begin
          state_d = R_DONE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      R_DONE:  state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // A completed refresh with nothing owed restarts the interval, so a coincident wrap is absorbed.
  always_comb begin
    wrap_s = (intv_q == CNT_LAST);
    clr_s  = ((state_q == R_IDLE) && clear_refresh) ||
             ((state_q == R_DONE) && (pend_q == 4'd0));
    dec_s  = (state_q == R_DONE) && (pend_q != 4'd0);
    inc_s  = wrap_s && !clr_s;

    if (clr_s || wrap_s) begin
      intv_d = CNT_ZERO;
    end else begin
      intv_d = intv_q + CNT_ONE;
    end

    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (inc_s && !dec_s) begin
      if (pend_q >= PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (dec_s && !inc_s) begin
      pend_d = pend_q - 4'd1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_comb begin
    pins_d = PIN_DESEL;
    case (state_d)
      R_PREA:  pins_d = PIN_PREA;
      R_REF:   pins_d = PIN_REF;
      default: pins_d = PIN_DESEL;
    endcase
    done_d = (state_d == R_DONE);
    busy_d = (state_d == R_PREA) || (state_d == R_TRP) ||
             (state_d == R_REF)  || (state_d == R_TRFC);
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_q <= R_IDLE;
      tmr_q   <= TMR_ZERO;
      intv_q  <= CNT_ZERO;
      pend_q  <= 4'd0;
      ovf_q   <= 1'b0;
      pins_q  <= PIN_DESEL;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      intv_q  <= intv_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pins_q  <= pins_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign refresh_almost = almost_s;
  assign refresh_done   = done_q;
  assign refresh_busy   = busy_q;
  assign ref_pending    = pend_q;
  assign ref_overflow   = ovf_q;
  assign cmd_cs_n       = pins_q[5];
  assign cmd_act_n      = pins_q[4];
  assign cmd_ras_n      = pins_q[3];
  assign cmd_cas_n      = pins_q[2];
  assign cmd_we_n       = pins_q[1];
  assign cmd_a10        = pins_q[0];

endmodule

// File: tb/tb_ref_sched.sv
// Directed bench for ref_sched with small timing parameters; cycle N = N-th cycle after reset release.
module tb_ref_sched;

  localparam int T_REFI      = 100;
  localparam int ALMOST_LEAD = 10;
  localparam int T_RP        = 4;
  localparam int T_RFC       = 20;

  localparam logic [5:0] PIN_DESEL = 6'b111110;
  localparam logic [5:0] PIN_PREA  = 6'b010101;
  localparam logic [5:0] PIN_REF   = 6'b010010;

`ifdef REF_POSTPONE_EN
  localparam int N_SEQ = 3;
`else
  localparam int N_SEQ = 1;
`endif

  logic       CK_t = 1'b0;
  logic       reset, clear_refresh, ref_go;
  logic       refresh_almost, refresh_done, refresh_busy, ref_overflow;
  logic [3:0] ref_pending;
  logic       cmd_cs_n, cmd_act_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10;
  logic [5:0] pins;
  logic       seen;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 CK_t = ~CK_t;

  assign pins = {cmd_cs_n, cmd_act_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10};

  ref_sched #(
    .T_REFI(T_REFI), .ALMOST_LEAD(ALMOST_LEAD), .T_RP(T_RP), .T_RFC(T_RFC), .MAX_POSTPONE(8)
  ) dut (
    .CK_t(CK_t), .reset(reset), .clear_refresh(clear_refresh), .ref_go(ref_go),
    .refresh_almost(refresh_almost), .refresh_done(refresh_done), .refresh_busy(refresh_busy),
    .ref_pending(ref_pending), .ref_overflow(ref_overflow),
    .cmd_cs_n(cmd_cs_n), .cmd_act_n(cmd_act_n), .cmd_ras_n(cmd_ras_n),
    .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n), .cmd_a10(cmd_a10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 'h%0h expected 'h%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK_t);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(output logic hit);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      step();
      hit = refresh_done;
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_refresh = 1'b0;
    ref_go = 1'b0;
    step();
    do_reset();

    // Reset state
    check("rst_pins", pins, PIN_DESEL);
    check("rst_almost", refresh_almost, 1'b0);
    check("rst_done", refresh_done, 1'b0);
    check("rst_busy", refresh_busy, 1'b0);
    check("rst_pend", ref_pending, 4'd0);
    check("rst_ovf", ref_overflow, 1'b0);

    // Interval timing and one refresh sequence
    run_to(50);  check("idle_pins", pins, PIN_DESEL);
    run_to(89);  check("almost_89", refresh_almost, 1'b0);
    run_to(90);  check("almost_90", refresh_almost, 1'b1);
    run_to(95);  ref_go = 1'b1;
    run_to(96);  check("prea_pins", pins, PIN_PREA);
                 check("prea_busy", refresh_busy, 1'b1);
    run_to(99);  check("trp_pins", pins, PIN_DESEL);
                 check("pend_99", ref_pending, 4'd0);
    run_to(100); check("ref_pins", pins, PIN_REF);
                 check("pend_100", ref_pending, 4'd1);
    run_to(119); check("done_119", refresh_done, 1'b0);
                 check("busy_119", refresh_busy, 1'b1);
    run_to(120); check("done_120", refresh_done, 1'b1);
                 check("busy_120", refresh_busy, 1'b0);
    run_to(121); check("done_121", refresh_done, 1'b0);
                 check("almost_121", refresh_almost, 1'b0);
                 check("pend_121", ref_pending, 4'd0);
    ref_go = 1'b0;
    run_to(140); check("post_pins", pins, PIN_DESEL);

    // Reset during tRFC aborts the sequence
    do_reset();
    run_to(95);  ref_go = 1'b1;
    run_to(100); check("r5_ref_pins", pins, PIN_REF);
    run_to(105); ref_go = 1'b0; reset = 1'b1;
    step();
    check("abort_pins", pins, PIN_DESEL);
    check("abort_busy", refresh_busy, 1'b0);
    check("abort_pend", ref_pending, 4'd0);
    check("abort_almost", refresh_almost, 1'b0);
    reset = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 30) begin
      step();
      seen = seen | refresh_done;
    end
    check("abort_no_done", seen, 1'b0);

    // clear_refresh / ref_go ignored mid-sequence; clear honoured in idle
    run_to(95);  ref_go = 1'b1;
    run_to(100); check("r6_ref_pins", pins, PIN_REF);
    run_to(105); clear_refresh = 1'b1; ref_go = 1'b0;
    run_to(119); clear_refresh = 1'b0;
                 check("r6_done_119", refresh_done, 1'b0);
    run_to(120); check("r6_done_120", refresh_done, 1'b1);
    run_to(121); check("r6_pend_121", ref_pending, 4'd0);
                 check("r6_almost_121", refresh_almost, 1'b0);
    run_to(189); check("r6_almost_189", refresh_almost, 1'b0);
    run_to(190); check("r6_almost_190", refresh_almost, 1'b1);
    run_to(191); clear_refresh = 1'b1;
    run_to(192); clear_refresh = 1'b0;
                 check("clr_almost_192", refresh_almost, 1'b0);
                 check("clr_pend_192", ref_pending, 4'd0);
    run_to(281); check("clr_almost_281", refresh_almost, 1'b0);
    run_to(282); check("clr_almost_282", refresh_almost, 1'b1);

    // Owed refreshes accumulate with ref_go low
    run_to(291); check("owe_pend_291", ref_pending, 4'd0);
    run_to(292); check("owe_pend_292", ref_pending, 4'd1);
    run_to(391); check("owe_ovf_391", ref_overflow, 1'b0);
    run_to(392);
`ifdef REF_POSTPONE_EN
    check("owe_pend_392", ref_pending, 4'd2);
    check("owe_ovf_392", ref_overflow, 1'b0);
    run_to(492); check("owe_pend_492", ref_pending, 4'd3);
`else
    check("owe_pend_392", ref_pending, 4'd1);
    check("owe_ovf_392", ref_overflow, 1'b1);
    run_to(492); check("owe_pend_492", ref_pending, 4'd1);
`endif

    // Drain owed refreshes back to back
    run_to(495); ref_go = 1'b1;
    for (int i = 0; i < N_SEQ; i++) begin
      wait_done(seen);
      check("drain_done", seen, 1'b1);
      step();
      check("drain_pend", ref_pending, 32'(N_SEQ - 1 - i));
    end
    ref_go = 1'b0;
    check("drain_almost", refresh_almost, 1'b0);
`ifdef REF_POSTPONE_EN
    check("final_ovf", ref_overflow, 1'b0);
`else
    check("final_ovf", ref_overflow, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
